// File: rtl/sad_coord_index_gen.sv
// sad_coord_index_gen: raster-walks a candidate region (x outer, y inner) and emits
// flat SAD indices (x << ROW_SHIFT) + y over a valid/ready handshake.
module sad_coord_index_gen #(
    parameter int IDX_W     = 32,
    parameter int ROW_SHIFT = 6,
    parameter int DIM_W     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] x_base,
    input  logic [IDX_W-1:0] y_base,
    input  logic [DIM_W-1:0] x_count,
    input  logic [DIM_W-1:0] y_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] index,
    output logic [IDX_W-1:0] x,
    output logic [IDX_W-1:0] y,
    output logic             last,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [IDX_W-1:0] y_b, nx, ny;
    logic [DIM_W-1:0] xc, yc, xo, yo, nxo, nyo;
    logic wrap;
    always_comb begin
        wrap = yo == yc - 1'b1;
        nyo  = wrap ? '0 : yo + 1'b1;
        nxo  = wrap ? xo + 1'b1 : xo;
        ny   = wrap ? y_b : y + 1'b1;
        nx   = wrap ? x + 1'b1 : x;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            index     <= '0;
            x         <= '0;
            y         <= '0;
            y_b       <= '0;
            xc        <= '0;
            yc        <= '0;
            xo        <= '0;
            yo        <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    y_b  <= y_base;
                    xc   <= x_count;
                    yc   <= y_count;
                    xo   <= '0;
                    yo   <= '0;
                    busy <= 1'b1;
                    if (x_count == '0 || y_count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= RUN;
                        out_valid <= 1'b1;
                        x         <= x_base;
                        y         <= y_base;
                        index     <= (x_base << ROW_SHIFT) + y_base;
                        last      <= x_count == DIM_W'(1) && y_count == DIM_W'(1);
                    end
                end
                RUN: if (out_ready) begin
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        last      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        xo    <= nxo;
                        yo    <= nyo;
                        x     <= nx;
                        y     <= ny;
                        index <= (nx << ROW_SHIFT) + ny;
                        last  <= nyo == yc - 1'b1 && nxo == xc - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sad_coord_index_gen.sv
// tb_sad_coord_index_gen: randomized and directed scans against a nested-loop region model.
module tb_sad_coord_index_gen;
    localparam int W = 32;
    localparam int D = 7;
    typedef struct {logic [W-1:0] i, x, y; logic l;} beat_t;
    logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
    logic [W-1:0] x_base = 0, y_base = 0;
    logic [D-1:0] x_count = 0, y_count = 0;
    logic out_valid, last, busy, done;
    logic [W-1:0] index, x, y;
    int errors = 0, checks = 0;
    logic [W-1:0] seen[$];
    logic [W-1:0] gold[6];

    sad_coord_index_gen #(.IDX_W(W), .ROW_SHIFT(6), .DIM_W(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_base(x_base), .y_base(y_base),
        .x_count(x_count), .y_count(y_count), .out_valid(out_valid), .out_ready(out_ready),
        .index(index), .x(x), .y(y), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_index"}, index, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random ready
    task automatic run_scan(input logic [W-1:0] xb, input logic [W-1:0] yb, input int xc,
                            input int yc, input int mode, input int inject, input int abort);
        beat_t q[$];
        beat_t b;
        int cyc = 0, acc = 0, dn = 0;
        logic rdy;
        seen.delete();
        for (int i = 0; i < xc; i++)
            for (int j = 0; j < yc; j++) begin
                b.x = xb + W'(i);
                b.y = yb + W'(j);
                b.i = b.x * 32'd64 + b.y;
                b.l = (i == xc - 1) && (j == yc - 1);
                q.push_back(b);
            end
        @(negedge clk);
        x_base = xb; y_base = yb; x_count = D'(xc); y_count = D'(yc); start = 1;
        @(negedge clk);
        start = 0;
        x_base = $urandom; y_base = $urandom; x_count = D'($urandom); y_count = D'($urandom);
        if (q.size() == 0) begin
            repeat (5) begin
                chk("zero_valid", out_valid, 0);
                if (done) dn++;
                @(negedge clk);
            end
            chk("zero_done_count", dn, 1);
            chk("zero_busy", busy, 0);
            return;
        end
        while (q.size() > 0) begin
            if (++cyc > 2000) begin
                chk("timeout_pending", q.size(), 0);
                return;
            end
            chk("valid", out_valid, 1);
            chk("done_low", done, 0);
            chk("busy_run", busy, 1);
            chk("index", index, q[0].i);
            chk("x", x, q[0].x);
            chk("y", y, q[0].y);
            chk("last", last, q[0].l);
            rdy = mode == 0 ? 1'b1 : mode == 1 ? logic'(cyc % 3 == 1) : logic'($urandom_range(0, 1));
            out_ready = rdy;
            if (cyc == inject) begin
                start = 1; x_base = $urandom; y_base = $urandom; x_count = 3; y_count = 3;
            end else start = 0;
            if (rdy) begin
                seen.push_back(index);
                void'(q.pop_front());
                acc++;
            end
            @(negedge clk);
            if (abort != 0 && acc == abort) begin
                rst_n = 0;
                #1 check_zero("abort");
                @(negedge clk);
                chk("abort_no_done", done, 0);
                rst_n = 1;
                out_ready = 0;
                return;
            end
        end
        start = 0;
        chk("end_done", done, 1);
        chk("end_valid", out_valid, 0);
        chk("end_busy", busy, 1);
        @(negedge clk);
        out_ready = 0;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        gold = '{133, 134, 135, 197, 198, 199};
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1;
        run_scan(2, 5, 2, 3, 0, 0, 0);
        chk("basic_count", seen.size(), 6);
        for (int i = 0; i < 6; i++) chk("basic_gold", seen[i], gold[i]);
        run_scan(2, 5, 2, 3, 1, 0, 0);
        chk("bp_count", seen.size(), 6);
        for (int i = 0; i < 6; i++) chk("bp_gold", seen[i], gold[i]);
        run_scan(9, 9, 0, 4, 0, 0, 0);
        run_scan(9, 9, 3, 0, 2, 0, 0);
        run_scan(10, 20, 3, 4, 0, 3, 0);
        run_scan(10, 20, 3, 4, 1, 5, 0);
        run_scan(7, 1, 3, 3, 0, 0, 2);
        run_scan(7, 1, 3, 3, 2, 0, 2);
        run_scan(100, 9, 2, 2, 2, 0, 0);
        run_scan(32'h03FF_FFFF, 63, 1, 1, 0, 0, 0);
        chk("wrap_hi", seen[0], 32'hFFFF_FFFF);
        run_scan(32'h0400_0000, 0, 1, 1, 2, 0, 0);
        chk("wrap_zero", seen[0], 0);
        repeat (10)
            run_scan($urandom, $urandom_range(0, 80), $urandom_range(1, 5),
                     $urandom_range(1, 5), 2, $urandom_range(0, 6), 0);
        run_scan(32'hFFFF_FFFE, 32'hFFFF_FFFE, 3, 70, 2, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
